// File: rtl/uart_bridge_pkg.sv
// Shared types and byte codes for the UART-to-register-bus command bridge.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddrW,
    StGetAddrR,
    StGetData,
    StBusWr,
    StBusRd,
    StReply
  } bridge_state_e;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam logic [7:0] RSP_ERR = 8'h45;

endpackage

// File: rtl/uart_bus_bridge_if.sv
// RX FIFO pop side, TX FIFO push side and register bus of the command bridge.
interface uart_bus_bridge_if;
  logic       rx_ready;
  logic [7:0] rx_byte;
  logic       rx_read;
  logic       tx_full;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       bus_ack;

  modport master (
    input  rx_ready, rx_byte, tx_full, bus_rdata, bus_ack,
    output rx_read, tx_start, tx_data, bus_addr, bus_wdata, bus_we, bus_re
  );

  modport slave (
    output rx_ready, rx_byte, tx_full, bus_rdata, bus_ack,
    input  rx_read, tx_start, tx_data, bus_addr, bus_wdata, bus_we, bus_re
  );
endinterface

// File: rtl/bridge_timeout_ctr.sv
// Saturating cycle counter with synchronous clear; expired is high while the count equals Limit.
module bridge_timeout_ctr #(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned Width = (Limit > 0) ? $clog2(Limit + 1) : 1;
  localparam logic [Width-1:0] LimitW = Width'(Limit);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LimitW)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LimitW);

endmodule

// File: rtl/uart_bus_bridge.sv
// Parses W/R commands popped from the UART RX FIFO, runs one register bus cycle and
// pushes a single reply byte into the TX FIFO.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 1000000,
  parameter int unsigned BUS_TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  uart_bus_bridge_if.master   br,
  output logic                busy
);

  bridge_state_e state_q, state_d;

  logic [7:0] addr_q, wdata_q, reply_q;
  logic       gap_q;
  logic       pop, in_get, in_bus;
  logic       byte_expired, bus_expired;
  logic       rx_read, tx_start, bus_we, bus_re;

  assign in_get = (state_q == StGetAddrW) || (state_q == StGetAddrR) || (state_q == StGetData);
  assign in_bus = (state_q == StBusWr) || (state_q == StBusRd);
  assign pop    = rx_read;

  bridge_timeout_ctr #(
    .Limit (BYTE_TIMEOUT)
  ) u_byte_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (pop || !in_get),
    .en      (in_get && !br.rx_ready),
    .expired (byte_expired)
  );

  bridge_timeout_ctr #(
    .Limit (BUS_TIMEOUT)
  ) u_bus_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_bus),
    .en      (in_bus),
    .expired (bus_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          if (br.rx_byte == CMD_WR) begin
            state_d = StGetAddrW;
          end else if (br.rx_byte == CMD_RD) begin
            state_d = StGetAddrR;
          end else begin
            state_d = StReply;
          end
        end
      end
      StGetAddrW: begin
        if (byte_expired) state_d = StIdle;
        else if (pop)     state_d = StGetData;
      end
      StGetAddrR: begin
        if (byte_expired) state_d = StIdle;
        else if (pop)     state_d = StBusRd;
      end
      StGetData: begin
        if (byte_expired) state_d = StIdle;
        else if (pop)     state_d = StBusWr;
      end
      StBusWr, StBusRd: begin
        if (br.bus_ack || bus_expired) state_d = StReply;
      end
      StReply: begin
        if (!br.tx_full) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are masked by rst so a reset drops requests in the same cycle.
  always_comb begin
    rx_read  = 1'b0;
    tx_start = 1'b0;
    bus_we   = 1'b0;
    bus_re   = 1'b0;
    unique case (state_q)
      StIdle, StGetAddrW, StGetAddrR, StGetData: begin
        rx_read = br.rx_ready && !gap_q && !byte_expired;
      end
      StBusWr: bus_we   = 1'b1;
      StBusRd: bus_re   = 1'b1;
      StReply: tx_start = !br.tx_full;
      default: ;
    endcase
    if (rst) begin
      rx_read  = 1'b0;
      tx_start = 1'b0;
      bus_we   = 1'b0;
      bus_re   = 1'b0;
    end
  end

  // gap_q blocks the cycle after a pop while the FIFO pointer catches up.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q   <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      reply_q <= 8'h00;
    end else begin
      gap_q <= pop;
      if (pop && ((state_q == StGetAddrW) || (state_q == StGetAddrR))) begin
        addr_q <= br.rx_byte;
      end
      if (pop && (state_q == StGetData)) begin
        wdata_q <= br.rx_byte;
      end
      if (pop && (state_q == StIdle) && (br.rx_byte != CMD_WR) && (br.rx_byte != CMD_RD)) begin
        reply_q <= RSP_BAD;
      end
      if (state_q == StBusWr) begin
        if (br.bus_ack)       reply_q <= RSP_OK;
        else if (bus_expired) reply_q <= RSP_ERR;
      end
      if (state_q == StBusRd) begin
        if (br.bus_ack)       reply_q <= br.bus_rdata;
        else if (bus_expired) reply_q <= RSP_ERR;
      end
    end
  end

  assign br.rx_read   = rx_read;
  assign br.tx_start  = tx_start;
  assign br.tx_data   = reply_q;
  assign br.bus_addr  = addr_q;
  assign br.bus_wdata = wdata_q;
  assign br.bus_we    = bus_we;
  assign br.bus_re    = bus_re;
  assign busy         = (state_q != StIdle);

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
Command decoder that sits directly downstream of the UART RX FIFO and upstream of the UART TX FIFO. It pops bytes from the RX FIFO and parses a fixed binary command protocol. It executes single-byte register reads and writes on a simple req/ack bus, then pushes one reply byte into the TX FIFO. Its job is to give the host a register-poke path over the serial link.

Parameters:
BYTE_TIMEOUT, 1000000, max clk cycles allowed between bytes of one command before the partial command is discarded
BUS_TIMEOUT, 255, max clk cycles to wait for bus_ack before replying with an error

Ports:
clk  in  1  main clock
rst  in  1  reset: synchronous, active-high
rx_ready  in  1  RX FIFO non-empty (combinational from FIFO pointers)
rx_byte  in  8  RX FIFO head byte
rx_read  out  1  one-cycle pop strobe to RX FIFO
tx_full  in  1  TX FIFO full
tx_start  out  1  one-cycle push strobe to TX FIFO
tx_data  out  8  byte to push; valid when tx_start=1
bus_addr  out  8  register address
bus_wdata  out  8  write data
bus_we  out  1  write request, level held until ack or timeout
bus_re  out  1  read request, level held until ack or timeout
bus_rdata  in  8  read data, sampled on the cycle bus_ack=1
bus_ack  in  1  single-cycle completion from target
busy  out  1  high in every state except IDLE

Behaviour:
- Protocol:
  - 0x57 'W', addr, data -> bus write; reply 0x4B 'K'.
  - 0x52 'R', addr -> bus read; reply is the read data byte.
  - Any other first byte -> reply 0x3F '?'; no bus cycle.
  - Bus timeout -> reply 0x45 'E'.
- Reset: state=IDLE. rx_read, tx_start, bus_we and bus_re are 0. bus_addr, bus_wdata and tx_data are 0x00. Both counters are cleared.
- RX pop rule:
  - A byte is consumed when rx_ready=1 and the FSM is in a byte-accepting state. That cycle: rx_byte is latched and rx_read=1.
  - The following cycle is a mandatory gap: no sample and no pop. This covers the upstream pointer update latency.
  - rx_read is never high on two consecutive cycles.
- FSM states:
  - IDLE: on pop, 'W'->GET_ADDR_W, 'R'->GET_ADDR_R, else ->REPLY with '?'.
  - GET_ADDR_W: on pop, latch bus_addr ->GET_DATA.
  - GET_ADDR_R: on pop, latch bus_addr ->BUS_RD.
  - GET_DATA: on pop, latch bus_wdata ->BUS_WR.
  - BUS_WR / BUS_RD:
    - Assert bus_we / bus_re from the cycle of entry.
    - On bus_ack: drop the request the next cycle; reply 'K' for a write, or bus_rdata latched on the ack cycle for a read; ->REPLY.
    - If bus_cnt reaches BUS_TIMEOUT with no ack: drop the request; reply 'E' ->REPLY.
    - bus_we and bus_re are never both 1.
  - REPLY:
    - Wait while tx_full=1.
    - When tx_full=0: tx_start=1 for exactly one cycle with tx_data = reply byte ->IDLE.
    - The next command byte may be popped no earlier than the cycle after tx_start.
- Inter-byte timeout:
  - byte_cnt clears on every pop.
  - It increments in GET_ADDR_W, GET_ADDR_R and GET_DATA while rx_ready=0.
  - On reaching BYTE_TIMEOUT: ->IDLE silently, with no reply and no bus cycle.
  - The counter is inactive in IDLE, BUS_* and REPLY.
- Counter widths: $clog2(BYTE_TIMEOUT+1) and $clog2(BUS_TIMEOUT+1). They saturate; they never wrap.
- Reset mid-operation: returns to IDLE within one cycle and drops bus_we and bus_re. A partial command is lost and not replayed.
- A bus_ack arriving outside BUS_* is ignored.
- A late bus_ack arriving after a timeout is ignored.
- Throughput: one command in flight; no pipelining of commands.

Decomposition:
- Shared package uart_bridge_pkg:
  - state enum;
  - command codes CMD_WR=0x57 and CMD_RD=0x52;
  - reply codes RSP_OK=0x4B, RSP_BAD=0x3F and RSP_ERR=0x45.
- One sub-module is natural: bridge_timeout_ctr, a parameterised saturating counter with clear, enable and expired outputs. It is instantiated twice, once for byte timeout and once for bus timeout.
- The FSM stays in the top module.

Test Plan:
- Write: feed 0x57,0x20,0xA5; bus acks 3 cycles after bus_we rises -> bus_addr=0x20, bus_wdata=0xA5, exactly one bus_we episode, then one tx_start with tx_data=0x4B.
- Read: feed 0x52,0x10; bus_rdata=0x3C with ack -> bus_re held until ack, then tx_data=0x3C.
- Bad command: feed 0x00 -> no bus_we/bus_re, tx_data=0x3F, FSM back in IDLE.
- Bus timeout: feed 0x52,0x11; never ack -> bus_re drops after BUS_TIMEOUT cycles, tx_data=0x45; a later injected ack is ignored.
- Byte timeout: feed 0x57,0x20, then stall BYTE_TIMEOUT cycles; then feed 0x52,0x05 -> no write occurs and the read completes normally.
- Back-pressure and pop spacing:
  - Hold tx_full=1 for 50 cycles during REPLY -> tx_start waits and fires once.
  - With rx_ready held high, rx_read pulses are separated by at least one idle cycle.
